adder_seq: RTL

ADDER_SEQ -- requirements
Module: adder_seq

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 31 +++
 rtl/adder_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// Optional signed-overflow output is enabled by defining ADDER_SEQ_OVF_EN.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index register is at least one bit even when a single chunk covers the word.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// Also exposes the carry into its MSB so the caller can derive signed overflow.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        // NOTE: blocking assignments here are intentional; 'c' ripples bit to bit within one evaluation.
        c        = cin;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/adder_seq.sv
// Sequential adder/subtractor processing CHUNK bits per cycle with a valid/ready handshake.
// Define ADDER_SEQ_OVF_EN to add the latched signed-overflow output 'ovf'.
module adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("adder_seq: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef ADDER_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    int                 lsb;
    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_s;
    logic               chunk_cout;
    logic               chunk_c_msb_in;

    always_comb begin
        lsb     = int'(idx_q) * CHUNK;
        chunk_a = a_q[lsb +: CHUNK];
        chunk_b = b_q[lsb +: CHUNK];
    end

    adder_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a        (chunk_a),
        .b        (chunk_b),
        .cin      (carry_q),
        .s        (chunk_s),
        .cout     (chunk_cout),
        .c_msb_in (chunk_c_msb_in)
    );

`ifndef ADDER_SEQ_OVF_EN
    logic unused_c_msb_in;
    assign unused_c_msb_in = chunk_c_msb_in;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtraction is a + ~b + 1, so invert B and force the carry in.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[lsb +: CHUNK] = chunk_s;
                carry_d             = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = chunk_cout;
`ifdef ADDER_SEQ_OVF_EN
                    ovf_d   = chunk_c_msb_in ^ chunk_cout;
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
